// File: rtl/ids_matcher_pkg.sv
// ids_matcher_pkg
//   Shared definitions for the IDS pattern-match stage:
//   - FSM state encoding (S_HDR, S_PLD)
//   - CTRL_EOP_* one-hot end-of-packet control values (CTRL_EOP_Bn = last valid byte n)
//   - pattern geometry (PATTERN_BYTES, byte/mask field positions)
//   - eop_last_byte(): index of the last valid byte in an EOP word
package ids_matcher_pkg;

   localparam logic [0:0] S_HDR = 1'b0;
   localparam logic [0:0] S_PLD = 1'b1;

   localparam logic [7:0] CTRL_EOP_B0 = 8'h80;
   localparam logic [7:0] CTRL_EOP_B1 = 8'h40;
   localparam logic [7:0] CTRL_EOP_B2 = 8'h20;
   localparam logic [7:0] CTRL_EOP_B3 = 8'h10;
   localparam logic [7:0] CTRL_EOP_B4 = 8'h08;
   localparam logic [7:0] CTRL_EOP_B5 = 8'h04;
   localparam logic [7:0] CTRL_EOP_B6 = 8'h02;
   localparam logic [7:0] CTRL_EOP_B7 = 8'h01;

   localparam int PATTERN_BYTES = 7;
   localparam int PAT_W         = 8 * PATTERN_BYTES;
   localparam int PAT_LSB       = 8;   // pattern bytes live in [63:8]
   localparam int MASK_LSB      = 0;   // mask lives in [6:0]

   // The highest set control bit marks the last valid byte; checks run from
   // byte 7 upward so the highest set bit is the one that sticks.
   function automatic logic [2:0] eop_last_byte(input logic [7:0] ctrl);
      logic [2:0] last;
      last = 3'd7;
      if (|(ctrl & CTRL_EOP_B6)) last = 3'd6;
      if (|(ctrl & CTRL_EOP_B5)) last = 3'd5;
      if (|(ctrl & CTRL_EOP_B4)) last = 3'd4;
      if (|(ctrl & CTRL_EOP_B3)) last = 3'd3;
      if (|(ctrl & CTRL_EOP_B2)) last = 3'd2;
      if (|(ctrl & CTRL_EOP_B1)) last = 3'd1;
      if (|(ctrl & CTRL_EOP_B0)) last = 3'd0;
      return last;
   endfunction

endpackage

// File: rtl/ids_matcher_if.sv
// ids_matcher_if
//   NetFPGA packet-stream bus: data word, control byte, write strobe and
//   ready back-pressure.
//   master: drives data/ctrl/wr, receives rdy
//   slave : receives data/ctrl/wr, drives rdy
interface ids_matcher_if #(
   parameter int DATA_WIDTH = 64,
   parameter int CTRL_WIDTH = DATA_WIDTH / 8
);
   logic [DATA_WIDTH-1:0] data;
   logic [CTRL_WIDTH-1:0] ctrl;
   logic                  wr;
   logic                  rdy;

   modport master (output data, output ctrl, output wr, input rdy);
   modport slave  (input data, input ctrl, input wr, output rdy);
endinterface

// File: rtl/ids_window_cmp.sv
// ids_window_cmp
//   Combinational 7-byte masked search over a 16-byte window formed by the
//   previous payload word followed by the current word. Candidate c (0..7)
//   ends at current byte c.
//   prev_word/cur_word : window words (byte 0 = [63:56])
//   pat_bytes/pat_mask : P0..P6 (P0 in the top byte) and per-byte enables
//   prev_valid         : prev_word belongs to this packet's payload
//   is_eop / ctrl      : current word is EOP; ctrl bounds the valid bytes
//   hit                : some valid candidate matched
module ids_window_cmp
   import ids_matcher_pkg::*;
(
   input  logic [63:0]            prev_word,
   input  logic [63:0]            cur_word,
   input  logic [PAT_W-1:0]       pat_bytes,
   input  logic [PATTERN_BYTES-1:0] pat_mask,
   input  logic                   prev_valid,
   input  logic                   is_eop,
   input  logic [7:0]             ctrl,
   output logic                   hit
);

   logic [127:0] win;
   logic [2:0]   last_byte;
   logic         cand_ok;
   logic         cand_valid;

   assign win       = {prev_word, cur_word};
   assign last_byte = eop_last_byte(ctrl);

   always_comb begin
      hit        = 1'b0;
      cand_ok    = 1'b0;
      cand_valid = 1'b0;
      for (int c = 0; c < 8; c++) begin
         cand_ok = 1'b1;
         for (int k = 0; k < PATTERN_BYTES; k++) begin
            if (pat_mask[k] &&
                (win[127 - 8*(c+2+k) -: 8] != pat_bytes[PAT_W-1 - 8*k -: 8]))
               cand_ok = 1'b0;
         end
         // Candidates 6 and 7 sit wholly in the current word; the others
         // reach back into the previous word.
         cand_valid = ((c >= 6) || prev_valid) &&
                      (!is_eop || (c <= int'(last_byte)));
         if (cand_ok && cand_valid)
            hit = 1'b1;
      end
   end

endmodule

// File: rtl/ids_matcher.sv
// ids_matcher
//   Pass-through stage that searches each packet payload for a masked 7-byte
//   pattern and counts matching packets.
//   clk, reset      : clock, asynchronous active-high reset
//   in_if (slave)   : packet stream from the FIFO controller; rdy = out_if.rdy
//   out_if (master) : same stream, registered once
//   pattern         : [63:8] bytes P0..P6, [6:0] mask, [7] reserved
//   match_en        : count enable sampled with the EOP word
//   count_clr       : synchronous clear of match_count (beats an increment)
//   match_count     : saturating count of matched packets
//   last_match      : most recent packet matched
module ids_matcher
   import ids_matcher_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int CTRL_WIDTH = DATA_WIDTH / 8
) (
   input  logic                clk,
   input  logic                reset,
   ids_matcher_if.slave        in_if,
   ids_matcher_if.master       out_if,
   input  logic [63:0]         pattern,
   input  logic                match_en,
   input  logic                count_clr,
   output logic [31:0]         match_count,
   output logic                last_match
);

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   logic [DATA_WIDTH-1:0]    data_p0;
   logic [CTRL_WIDTH-1:0]    ctrl_p0;
   logic                     vld_p0;

   logic [0:0]               state;
   logic [DATA_WIDTH-1:0]    prev_word;
   logic                     prev_valid;
   logic                     flag;
   logic [PAT_W-1:0]         pat_bytes_q;
   logic [PATTERN_BYTES-1:0] pat_mask_q;
   logic [31:0]              count_q;
   logic                     last_match_q;

   logic                     is_payload;
   logic                     is_eop;
   logic                     eop_acc;
   logic                     win_hit;
   logic                     pkt_hit;
   logic [PAT_W-1:0]         cmp_bytes;
   logic [PATTERN_BYTES-1:0] cmp_mask;
   logic                     cmp_prev_valid;
   logic                     pattern_unused;

   assign pattern_unused = pattern[7];   // reserved bit

   assign in_if.rdy   = out_if.rdy;
   assign out_if.data = data_p0;
   assign out_if.ctrl = ctrl_p0;
   assign out_if.wr   = vld_p0;

   assign is_payload = (in_if.ctrl == '0);
   assign is_eop     = (state == S_PLD) && !is_payload;
   assign eop_acc    = in_if.wr && is_eop;

   // The first payload word is searched with the live pattern, which is the
   // value latched on that same edge; later words use the latched copy.
   assign cmp_bytes      = (state == S_HDR) ? pattern[PAT_LSB +: PAT_W] : pat_bytes_q;
   assign cmp_mask       = (state == S_HDR) ? pattern[MASK_LSB +: PATTERN_BYTES] : pat_mask_q;
   assign cmp_prev_valid = (state == S_PLD) && prev_valid;
   assign pkt_hit        = flag | win_hit;

   ids_window_cmp u_cmp (
      .prev_word  (prev_word),
      .cur_word   (in_if.data),
      .pat_bytes  (cmp_bytes),
      .pat_mask   (cmp_mask),
      .prev_valid (cmp_prev_valid),
      .is_eop     (is_eop),
      .ctrl       (in_if.ctrl),
      .hit        (win_hit)
   );

   // Stage p0: one-cycle pass-through register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_p0 <= '0;
         ctrl_p0 <= '0;
         vld_p0  <= 1'b0;
      end else begin
         data_p0 <= in_if.data;
         ctrl_p0 <= in_if.ctrl;
         vld_p0  <= in_if.wr;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_HDR;
         prev_word   <= '0;
         prev_valid  <= 1'b0;
         flag        <= 1'b0;
         pat_bytes_q <= '0;
         pat_mask_q  <= '0;
      end else if (in_if.wr) begin
         if (state == S_HDR) begin
            if (is_payload) begin
               state       <= S_PLD;
               pat_bytes_q <= pattern[PAT_LSB +: PAT_W];
               pat_mask_q  <= pattern[MASK_LSB +: PATTERN_BYTES];
               flag        <= win_hit;
               prev_word   <= in_if.data;
               prev_valid  <= 1'b1;
            end
         end else begin
            if (is_payload) begin
               flag       <= pkt_hit;
               prev_word  <= in_if.data;
               prev_valid <= 1'b1;
            end else begin
               state      <= S_HDR;
               flag       <= 1'b0;
               prev_valid <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q      <= '0;
         last_match_q <= 1'b0;
      end else begin
         if (eop_acc)
            last_match_q <= pkt_hit;
         if (count_clr)
            count_q <= '0;
         else if (eop_acc && pkt_hit && match_en)
            count_q <= sat_inc(count_q);
      end
   end

   assign match_count = count_q;
   assign last_match  = last_match_q;

endmodule

// File: tb/tb_ids_matcher.sv
// tb_ids_matcher
//   Directed bench for ids_matcher: reset values, aligned / straddling /
//   EOP-truncated matches, masking, count enable, saturation and clear,
//   back-pressure pass-through and reset in the middle of a packet.
module tb_ids_matcher;
   import ids_matcher_pkg::*;

   localparam logic [63:0] PAT_ABC  = 64'h4142_4344_4546_477F;
   localparam logic [63:0] PAT_AXC  = 64'h4100_4300_0000_0005;
   localparam logic [63:0] PAT_ANY  = 64'hDEAD_BEEF_CAFE_F080;
   localparam logic [63:0] PAT_JUNK = 64'h1111_1111_1111_1111;

   logic        clk;
   logic        reset;
   logic [63:0] pattern;
   logic        match_en;
   logic        count_clr;
   logic [31:0] match_count;
   logic        last_match;

   int n_tests;
   int n_fail;

   ids_matcher_if #(.DATA_WIDTH(64)) in_if ();
   ids_matcher_if #(.DATA_WIDTH(64)) out_if ();

   ids_matcher #(.DATA_WIDTH(64)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_if       (in_if.slave),
      .out_if      (out_if.master),
      .pattern     (pattern),
      .match_en    (match_en),
      .count_clr   (count_clr),
      .match_count (match_count),
      .last_match  (last_match)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task send_word(input logic [7:0] c, input logic [63:0] d);
      @(negedge clk);
      in_if.ctrl = c;
      in_if.data = d;
      in_if.wr   = 1'b1;
   endtask

   task idle();
      @(negedge clk);
      in_if.wr  = 1'b0;
      count_clr = 1'b0;
   endtask

   // hdr, zero word, ABCDEFG at bytes 0..6 of payload word 1, zero EOP
   task send_abc_packet();
      send_word(8'hFF, 64'h0123_4567_89AB_CDEF);
      send_word(8'h00, 64'h0);
      send_word(8'h00, 64'h4142_4344_4546_4700);
      send_word(CTRL_EOP_B7, 64'h0);
   endtask

   task test_reset();
      repeat (2) @(negedge clk);
      n_tests++; if (out_if.data !== 64'h0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", out_if.data); end
      n_tests++; if (out_if.ctrl !== 8'h0) begin n_fail++; $display("FAIL reset_out_ctrl: got %h want 0", out_if.ctrl); end
      n_tests++; if (out_if.wr !== 1'b0) begin n_fail++; $display("FAIL reset_out_wr: got %b want 0", out_if.wr); end
      n_tests++; if (match_count !== 32'h0) begin n_fail++; $display("FAIL reset_count: got %h want 0", match_count); end
      n_tests++; if (last_match !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b want 0", last_match); end
      n_tests++; if (in_if.rdy !== 1'b1) begin n_fail++; $display("FAIL reset_in_rdy: got %b want 1", in_if.rdy); end
      reset = 1'b0;
   endtask

   task test_aligned();
      pattern = PAT_ABC;
      send_abc_packet();
      n_tests++; if (match_count !== 32'd0) begin n_fail++; $display("FAIL aligned_pre_eop: got %0d want 0", match_count); end
      idle();
      n_tests++; if (match_count !== 32'd1) begin n_fail++; $display("FAIL aligned_count: got %0d want 1", match_count); end
      n_tests++; if (last_match !== 1'b1) begin n_fail++; $display("FAIL aligned_last: got %b want 1", last_match); end
      n_tests++; if ({out_if.wr, out_if.ctrl} !== 9'h101) begin n_fail++; $display("FAIL aligned_passthru: got %h want 101", {out_if.wr, out_if.ctrl}); end
   endtask

   task test_straddle();
      pattern = PAT_ABC;
      send_word(8'hFF, 64'h0);
      send_word(8'h00, 64'h0);
      send_word(8'h00, 64'h0);
      pattern = PAT_JUNK;   // mid-packet change must not apply
      send_word(8'h00, 64'h0000_0000_0041_4243);
      send_word(8'h00, 64'h4445_4647_0000_0000);
      send_word(CTRL_EOP_B7, 64'h0);
      idle();
      n_tests++; if (match_count !== 32'd2) begin n_fail++; $display("FAIL straddle_count: got %0d want 2", match_count); end
      n_tests++; if (last_match !== 1'b1) begin n_fail++; $display("FAIL straddle_last: got %b want 1", last_match); end
   endtask

   task test_eop_trunc();
      pattern = PAT_ABC;
      // pattern at EOP bytes 1..7, but only bytes 0..4 are valid
      send_word(8'hFF, 64'h0);
      send_word(8'h00, 64'h0);
      send_word(CTRL_EOP_B4, 64'h0041_4243_4445_4647);
      idle();
      n_tests++; if (match_count !== 32'd2) begin n_fail++; $display("FAIL eop_trunc_count: got %0d want 2", match_count); end
      n_tests++; if (last_match !== 1'b0) begin n_fail++; $display("FAIL eop_trunc_last: got %b want 0", last_match); end
      // same word with all 8 bytes valid does match
      send_word(8'hFF, 64'h0);
      send_word(8'h00, 64'h0);
      send_word(CTRL_EOP_B7, 64'h0041_4243_4445_4647);
      idle();
      n_tests++; if (match_count !== 32'd3) begin n_fail++; $display("FAIL eop_full_count: got %0d want 3", match_count); end
      n_tests++; if (last_match !== 1'b1) begin n_fail++; $display("FAIL eop_full_last: got %b want 1", last_match); end
   endtask

   task test_mask();
      pattern  = PAT_AXC;
      match_en = 1'b0;
      send_word(8'hFF, 64'h0);
      send_word(8'h00, 64'h4199_4312_3456_7890);
      send_word(CTRL_EOP_B7, 64'h0);
      idle();
      n_tests++; if (match_count !== 32'd3) begin n_fail++; $display("FAIL mask_noen_count: got %0d want 3", match_count); end
      n_tests++; if (last_match !== 1'b1) begin n_fail++; $display("FAIL mask_noen_last: got %b want 1", last_match); end
      match_en = 1'b1;
      send_word(8'hFF, 64'h0);
      send_word(8'h00, 64'h4199_4312_3456_7890);
      send_word(CTRL_EOP_B7, 64'h0);
      idle();
      n_tests++; if (match_count !== 32'd4) begin n_fail++; $display("FAIL mask_en_count: got %0d want 4", match_count); end
      send_word(8'hFF, 64'h0);
      send_word(8'h00, 64'h4199_4412_3456_7890);
      send_word(CTRL_EOP_B7, 64'h0);
      idle();
      n_tests++; if (match_count !== 32'd4) begin n_fail++; $display("FAIL mask_miss_count: got %0d want 4", match_count); end
      n_tests++; if (last_match !== 1'b0) begin n_fail++; $display("FAIL mask_miss_last: got %b want 0", last_match); end
      pattern = PAT_ANY;   // empty mask matches anything
      send_word(8'hFF, 64'h0);
      send_word(8'h00, 64'h1111_2222_3333_4444);
      send_word(CTRL_EOP_B7, 64'h0);
      idle();
      n_tests++; if (match_count !== 32'd5) begin n_fail++; $display("FAIL mask_zero_count: got %0d want 5", match_count); end
      n_tests++; if (last_match !== 1'b1) begin n_fail++; $display("FAIL mask_zero_last: got %b want 1", last_match); end
   endtask

   task test_saturate();
      pattern = PAT_ABC;
      @(negedge clk);
      force dut.count_q = 32'hFFFF_FFFE;
      #1;
      release dut.count_q;
      n_tests++; if (match_count !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL sat_preload: got %h want fffffffe", match_count); end
      send_abc_packet();
      idle();
      n_tests++; if (match_count !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sat_reach: got %h want ffffffff", match_count); end
      send_abc_packet();
      idle();
      n_tests++; if (match_count !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sat_hold: got %h want ffffffff", match_count); end
      send_word(8'hFF, 64'h0);
      send_word(8'h00, 64'h0);
      send_word(8'h00, 64'h4142_4344_4546_4700);
      count_clr = 1'b1;
      send_word(CTRL_EOP_B7, 64'h0);
      idle();
      n_tests++; if (match_count !== 32'h0) begin n_fail++; $display("FAIL clr_wins: got %h want 0", match_count); end
      n_tests++; if (last_match !== 1'b1) begin n_fail++; $display("FAIL clr_last: got %b want 1", last_match); end
   endtask

   task test_backpressure();
      logic [63:0] words [10];
      logic [7:0]  ctrls [10];
      logic [63:0] exp_d;
      logic [7:0]  exp_c;
      logic        exp_w;
      logic        rdy;
      int          idx;
      int          cyc;
      pattern = PAT_ABC;
      for (int i = 0; i < 10; i++) begin
         words[i] = 64'h1000_0000_0000_0000 + 64'(i) * 64'h0101_0101;
         ctrls[i] = 8'h00;
      end
      ctrls[0] = 8'hFF;
      ctrls[9] = CTRL_EOP_B7;
      words[4] = 64'h4142_4344_4546_4700;
      @(negedge clk);
      in_if.wr = 1'b0; in_if.data = 64'h0; in_if.ctrl = 8'h0;
      rdy = 1'b1; out_if.rdy = rdy;
      exp_d = 64'h0; exp_c = 8'h0; exp_w = 1'b0;
      idx = 0; cyc = 0;
      while (cyc < 40 && !(idx == 10 && exp_w == 1'b0)) begin
         @(negedge clk);
         n_tests++;
         if ({out_if.data, out_if.ctrl, out_if.wr} !== {exp_d, exp_c, exp_w}) begin
            n_fail++;
            $display("FAIL bp_passthru cyc %0d: got %h/%h/%b want %h/%h/%b", cyc,
                     out_if.data, out_if.ctrl, out_if.wr, exp_d, exp_c, exp_w);
         end
         n_tests++; if (in_if.rdy !== rdy) begin n_fail++; $display("FAIL bp_in_rdy cyc %0d: got %b want %b", cyc, in_if.rdy, rdy); end
         rdy = ~rdy;
         out_if.rdy = rdy;
         if (rdy && idx < 10) begin
            in_if.data = words[idx]; in_if.ctrl = ctrls[idx]; in_if.wr = 1'b1;
            idx++;
         end else begin
            in_if.wr = 1'b0;
         end
         exp_d = in_if.data; exp_c = in_if.ctrl; exp_w = in_if.wr;
         cyc++;
      end
      n_tests++; if (idx != 10 || cyc >= 40) begin n_fail++; $display("FAIL bp_timeout: sent %0d words want 10", idx); end
      out_if.rdy = 1'b1;
      n_tests++; if (match_count !== 32'd1) begin n_fail++; $display("FAIL bp_count: got %0d want 1", match_count); end
      n_tests++; if (last_match !== 1'b1) begin n_fail++; $display("FAIL bp_last: got %b want 1", last_match); end
   endtask

   task test_reset_mid_packet();
      pattern = PAT_ABC;
      send_word(8'hFF, 64'h0);
      send_word(8'h00, 64'h4142_4344_4546_4700);
      send_word(8'h00, 64'h0000_0000_0041_4243);
      idle();
      #2 reset = 1'b1;
      #1;
      n_tests++; if ({out_if.data, out_if.ctrl, out_if.wr} !== 73'h0) begin n_fail++; $display("FAIL rst_mid_out: got %h/%h/%b want 0", out_if.data, out_if.ctrl, out_if.wr); end
      n_tests++; if (match_count !== 32'h0) begin n_fail++; $display("FAIL rst_mid_count: got %h want 0", match_count); end
      n_tests++; if (last_match !== 1'b0) begin n_fail++; $display("FAIL rst_mid_last: got %b want 0", last_match); end
      n_tests++; if (dut.state !== S_HDR) begin n_fail++; $display("FAIL rst_mid_state: got %b want %b", dut.state, S_HDR); end
      @(negedge clk);
      reset = 1'b0;
      // tail of the straddle must not combine with the abandoned word
      send_word(8'h00, 64'h4445_4647_0000_0000);
      send_word(CTRL_EOP_B7, 64'h0);
      idle();
      n_tests++; if (match_count !== 32'h0) begin n_fail++; $display("FAIL rst_after_count: got %h want 0", match_count); end
      n_tests++; if (last_match !== 1'b0) begin n_fail++; $display("FAIL rst_after_last: got %b want 0", last_match); end
   endtask

   initial begin
      n_tests = 0; n_fail = 0;
      reset = 1'b1;
      in_if.data = 64'h0; in_if.ctrl = 8'h0; in_if.wr = 1'b0;
      out_if.rdy = 1'b1;
      pattern = 64'h0; match_en = 1'b1; count_clr = 1'b0;
      test_reset();
      test_aligned();
      test_straddle();
      test_eop_trunc();
      test_mask();
      test_saturate();
      test_backpressure();
      test_reset_mid_packet();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
